gpio_defaults_loader: RTL and testbench
=======================================

# gpio_defaults_loader

Controller that sequences the GPIO pad configuration shift chain after power-up or on firmware request. It captures a flattened vector of per-pad default configuration words, normally driven by the per-pad defaults ROM blocks, and runs three phases: pulses the chain reset, shifts every bit out serially, then latches the chain. It sits in the housekeeping clock domain between the defaults ROMs and the pad control blocks.

## Interface

Parameters:
- `NUM_PADS`, default 19: number of pads on the chain.
- `CFG_BITS`, default 13: configuration bits per pad.
- `CLK_DIV`, default 2: `wb_clk_i` cycles per half period of `serial_clock`. Must be ≥1.

Ports:
- `wb_clk_i` input 1: the block's single clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `start` input 1: request a load; sampled only in IDLE.
- `pad_config` input NUM_PADS*CFG_BITS: pad k occupies bits [k*CFG_BITS +: CFG_BITS].
- `serial_clock` output 1: chain shift clock.
- `serial_data` output 1: chain data; enters pad 0.
- `serial_load` output 1: chain latch strobe.
- `serial_resetn` output 1: chain reset, active-low.
- `busy` output 1: high from the cycle after start is accepted until the cycle before `done`.
- `done` output 1: one-cycle completion pulse.

## Operation

Reset values, all registered outputs:
- `serial_clock`=0, `serial_data`=0, `serial_load`=0.
- `serial_resetn`=1, `busy`=0, `done`=0.
- State returns to IDLE and all counters clear.

States:
- **IDLE**: if `start`=1, load `pad_config` into a shadow register and go to RST_CHAIN. Later changes on `pad_config` have no effect.
- **RST_CHAIN**: `serial_resetn`=0 for exactly 4 cycles, then go to SHIFT.
- **SHIFT**: N = NUM_PADS*CFG_BITS bits.
  - Order: pad NUM_PADS-1 first, pad 0 last; MSB first within each pad.
  - Each bit: `serial_data` updates on the cycle `serial_clock` goes low. `serial_clock` stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Data is stable across every rising edge of `serial_clock`.
  - After the high phase of bit N-1, go to LATCH.
- **LATCH**: `serial_clock`=0 and `serial_load`=1 for 2*CLK_DIV cycles, then go to DONE.
- **DONE**: `done`=1 and `busy`=0 for one cycle, then go to IDLE. `start` is ignored in this cycle.

Other rules:
- `start` outside IDLE is ignored; requests are not queued.
- `serial_data` holds its last value outside SHIFT.
- Synchronous reset in any state aborts the load. The next edge applies the reset values, so a partial chain load is not latched because `serial_load` never rises.
- Counters: bit index width $clog2(N+1); phase counter width $clog2(2*CLK_DIV+1). No wrap inside a load.

## Timing

Cycle 0 is the edge where `start` is sampled in IDLE.

- Cycles 1–4: RST_CHAIN, `busy`=1.
- Cycles 5 to 4+2*CLK_DIV*N: SHIFT.
  - Bit i has `serial_clock` low at cycles 5+2*CLK_DIV*i to 4+2*CLK_DIV*i+CLK_DIV.
  - It is high for the following CLK_DIV cycles.
- Next 2*CLK_DIV cycles: LATCH.
- `done` is high at cycle 5+2*CLK_DIV*(N+1). With the defaults (N=247) that is cycle 997.
- A new `start` can be accepted at cycle 6+2*CLK_DIV*(N+1) at the earliest.
- Latency from `start` to `done` is fixed; there is no dependency on data.

## Test plan

- **Default load**: pad k config = k with defaults, `start` pulsed once.
  - Captured bit stream = pad 18 down to pad 0, each 13 bits MSB-first, 247 rising edges.
  - `serial_load` high cycles 993–996, `done` at cycle 997, `busy` high cycles 1–996.
- **CLK_DIV=1, NUM_PADS=2, CFG_BITS=4, config 0xA5**:
  - Stream 1,0,1,0,0,1,0,1.
  - `serial_clock` toggles every cycle.
  - `done` at cycle 23.
- **Chain reset and latch shape**:
  - `serial_resetn` low exactly in cycles 1–4.
  - `serial_data` is constant across every `serial_clock` rising edge.
  - `serial_clock`=0 throughout `serial_load`.
- **Shadow capture and ignored start**:
  - Change `pad_config` to all-ones at cycle 2 and pulse `start` at cycle 100: stream still equals the original config, and only one `done` occurs.
  - `start` during DONE is ignored; `start` the next cycle is accepted.
- **Reset mid-shift**:
  - Assert `wb_rst_i` at cycle 300: the next edge shows all outputs at their reset values.
  - No `serial_load` pulse and no `done`.
  - A fresh `start` then completes a full load normally.
- **Back-to-back loads**: two loads with different configs each produce a correct stream and `done` at the correct cycle.

Source files
------------

// File: rtl/gpio_defaults_loader_if.sv
// Bundle between the defaults loader, its requester and the pad configuration chain.
// The master side is the loader; the slave side supplies start/pad_config and watches the chain.
interface gpio_defaults_loader_if #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = 13
);
  logic                         start;
  logic [NUM_PADS*CFG_BITS-1:0] pad_config;
  logic                         serial_clock;
  logic                         serial_data;
  logic                         serial_load;
  logic                         serial_resetn;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, pad_config,
    output serial_clock, serial_data, serial_load, serial_resetn, busy, done
  );

  modport slave (
    output start, pad_config,
    input  serial_clock, serial_data, serial_load, serial_resetn, busy, done
  );
endinterface

// File: rtl/gpio_defaults_loader.sv
// Sequences the GPIO pad configuration chain: chain reset pulse, serial shift of every
// captured default bit (last pad first, MSB first), then a latch strobe and a done pulse.
module gpio_defaults_loader #(
  parameter int NUM_PADS = 19,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  gpio_defaults_loader_if.master bus
);
  localparam int N     = NUM_PADS * CFG_BITS;
  localparam int BIT_W = $clog2(N + 1);
  localparam int PH_W  = $clog2(2 * CLK_DIV + 1);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(N - 1);
  localparam logic [PH_W-1:0]  PH_LOW_END = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(3);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RST_CHAIN = 3'd1;
  localparam logic [2:0] ST_SHIFT     = 3'd2;
  localparam logic [2:0] ST_LATCH     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]       state;
  logic [BIT_W-1:0] bit_idx;
  logic [PH_W-1:0]  phase;
  logic [N-1:0]     shadow;

  // NOTE: the shadow is a pure data register that is always fully loaded before it is
  // read, so it carries no reset; this keeps it out of the reset tree.
  always_ff @(posedge wb_clk_i) begin
    if (state == ST_IDLE && bus.start) begin
      shadow <= bus.pad_config;
    end else if (state == ST_SHIFT && phase == '0) begin
      shadow <= {shadow[N-2:0], 1'b0};
    end
  end

  // The state register describes the cycle the next edge produces, so every chain
  // output is registered and changes exactly on the cycle boundaries of its phase.
  // NOTE: non-blocking assignments make every register in this block sample the
  // pre-edge values, so the order of statements below does not matter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state             <= ST_IDLE;
      bit_idx           <= '0;
      phase             <= '0;
      bus.serial_clock  <= 1'b0;
      bus.serial_data   <= 1'b0;
      bus.serial_load   <= 1'b0;
      bus.serial_resetn <= 1'b1;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state <= ST_RST_CHAIN;
            phase <= '0;
          end
        end

        ST_RST_CHAIN: begin
          bus.serial_resetn <= 1'b0;
          bus.busy          <= 1'b1;
          if (phase == RST_LAST) begin
            phase   <= '0;
            bit_idx <= '0;
            state   <= ST_SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_SHIFT: begin
          bus.serial_resetn <= 1'b1;
          // Low for the first CLK_DIV counts, high for the rest; data moves only
          // when the clock drops, so it is settled long before the rising edge.
          bus.serial_clock  <= (phase > PH_LOW_END);
          if (phase == '0) begin
            bus.serial_data <= shadow[N-1];
          end
          if (phase == PH_LAST) begin
            phase <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= ST_LATCH;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_LATCH: begin
          bus.serial_clock <= 1'b0;
          bus.serial_load  <= 1'b1;
          if (phase == PH_LAST) begin
            phase <= '0;
            state <= ST_DONE;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_DONE: begin
          bus.serial_load <= 1'b0;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          state           <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_defaults_loader.sv
// Bench for gpio_defaults_loader: a default-size and a small chain instance, checked
// against a bit-stream/timing model derived from the pad ordering and phase lengths.
module tb_gpio_defaults_loader;
  typedef logic [246:0] cfg_t;

  typedef struct {
    int   which;     // 0: 19x13 CLK_DIV=2, 1: 2x4 CLK_DIV=1
    cfg_t cfg;
    int   exp_done;  // cycle of the done pulse relative to the start edge
    bit   hold;      // raise start during DONE and chain the next load straight on
  } vec_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gpio_defaults_loader_if #(.NUM_PADS(19), .CFG_BITS(13)) b0 ();
  gpio_defaults_loader_if #(.NUM_PADS(2),  .CFG_BITS(4))  b1 ();

  gpio_defaults_loader #(.NUM_PADS(19), .CFG_BITS(13), .CLK_DIV(2)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst0),
    .bus      (b0)
  );

  gpio_defaults_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) u_small (
    .wb_clk_i (clk),
    .wb_rst_i (rst1),
    .bus      (b1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // {serial_clock, serial_data, serial_load, serial_resetn, busy, done}
  function automatic logic [5:0] outs(input int which);
    if (which == 0)
      return {b0.serial_clock, b0.serial_data, b0.serial_load, b0.serial_resetn, b0.busy, b0.done};
    return {b1.serial_clock, b1.serial_data, b1.serial_load, b1.serial_resetn, b1.busy, b1.done};
  endfunction

  task automatic drive(input int which, input logic st, input cfg_t cfg);
    if (which == 0) begin
      b0.start      = st;
      b0.pad_config = cfg;
    end else begin
      b1.start      = st;
      b1.pad_config = cfg[7:0];
    end
  endtask

  function automatic cfg_t rand_cfg();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[246:0];
  endfunction

  // Called at a negedge; returns at the negedge that shows done (or when the budget runs out).
  task automatic do_load(input int which, input cfg_t cfg, input int exp_done, input bit hold,
                         input string tag);
    int   pads  = (which == 0) ? 19 : 2;
    int   cb    = (which == 0) ? 13 : 4;
    int   d     = (which == 0) ? 2 : 1;
    int   n     = pads * cb;
    int   pulse = (exp_done > 110) ? 100 : 10;
    bit   exp_q[$];
    bit   got_q[$];
    int   rstn_err = 0, busy_err = 0, load_err = 0, clk_in_load = 0;
    int   unstable = 0, high = 0, done_at = -1, diff = 0, lim;
    logic [5:0] o;
    logic prev_clk = 1'b0, prev_data = 1'b0, st = 1'b1;
    cfg_t cur = cfg;

    for (int p = pads - 1; p >= 0; p--)
      for (int b = cb - 1; b >= 0; b--)
        exp_q.push_back(cfg[p*cb + b]);

    drive(which, st, cur);
    for (int c = 0; c <= exp_done + 20; c++) begin
      @(negedge clk);
      o = outs(which);
      if (o[2] != !(c >= 1 && c <= 4)) rstn_err++;
      if (o[1] != (c >= 1 && c < exp_done)) busy_err++;
      if (o[3] != (c >= exp_done - 2*d && c < exp_done)) load_err++;
      if (o[3] && o[5]) clk_in_load++;
      if (o[5]) high++;
      if (o[5] && !prev_clk) begin
        got_q.push_back(o[4]);
        if (o[4] != prev_data) unstable++;
      end
      prev_clk  = o[5];
      prev_data = o[4];
      if (c == 0) st = 1'b0;
      if (c == 1) cur = '1;
      if (c == pulse - 1) st = 1'b1;
      if (c == pulse) st = 1'b0;
      if (hold && c == exp_done - 1) st = 1'b1;
      drive(which, st, cur);
      if (o[0]) begin
        done_at = c;
        break;
      end
    end

    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (got_q[i] != exp_q[i]) diff++;

    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_resetn_shape"}, rstn_err, 0);
    check({tag, "_busy_shape"}, busy_err, 0);
    check({tag, "_load_shape"}, load_err, 0);
    check({tag, "_clk_in_load"}, clk_in_load, 0);
    check({tag, "_data_unstable"}, unstable, 0);
    check({tag, "_rising_edges"}, got_q.size(), n);
    check({tag, "_clk_high_cycles"}, high, n * d);
    check({tag, "_stream_bits_wrong"}, diff, 0);
  endtask

  task automatic abort_load();
    int   bad_ev = 0;
    logic [5:0] o;
    drive(0, 1'b1, '1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      o = outs(0);
      if (o[3] || o[0]) bad_ev++;
      if (c == 0) drive(0, 1'b0, '1);
      if (c == 299) begin
        check("abort_busy_before", int'(o[1]), 1);
        check("abort_data_before", int'(o[4]), 1);
        rst0 = 1'b1;
      end
    end
    @(negedge clk);
    check("abort_reset_outs", int'(outs(0)), int'(6'b000100));
    rst0 = 1'b0;
    repeat (30) begin
      @(negedge clk);
      o = outs(0);
      if (o[3] || o[0] || o[1]) bad_ev++;
    end
    check("abort_no_load_done", bad_ev, 0);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (b0.busy || b0.done || b0.serial_load || b1.busy || b1.done || b1.serial_load) act++;
    end
    check(tag, act, 0);
  endtask

  initial begin
    cfg_t c_def;
    vec_t tbl[4];

    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("reset_outs_big", int'(outs(0)), int'(6'b000100));
    check("reset_outs_small", int'(outs(1)), int'(6'b000100));
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    c_def = '0;
    for (int k = 0; k < 19; k++) c_def[k*13 +: 13] = 13'(k);

    tbl[0] = '{which: 0, cfg: c_def,            exp_done: 997, hold: 1'b1};
    tbl[1] = '{which: 0, cfg: rand_cfg(),       exp_done: 997, hold: 1'b0};
    tbl[2] = '{which: 1, cfg: cfg_t'(8'hA5),    exp_done: 23,  hold: 1'b1};
    tbl[3] = '{which: 1, cfg: rand_cfg(),       exp_done: 23,  hold: 1'b0};

    for (int i = 0; i < 4; i++) begin
      do_load(tbl[i].which, tbl[i].cfg, tbl[i].exp_done, tbl[i].hold, $sformatf("vec%0d", i));
      if (!tbl[i].hold) idle_check(5, $sformatf("vec%0d_idle_after", i));
    end

    abort_load();
    do_load(0, rand_cfg(), 997, 1'b0, "post_abort");
    idle_check(40, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
